// File: rtl/afifo_rd_ctrl_if.sv
// afifo_rd_ctrl_if: valid/ready output stream of the async FIFO read-side drain engine.
`default_nettype none

interface afifo_rd_ctrl_if #(
  parameter int BITWID = 8
) ();
  logic              m_vld;
  logic              m_rdy;
  logic [BITWID-1:0] m_dat;
  logic              m_last;

  modport master (output m_vld, output m_dat, output m_last, input m_rdy);
  modport slave  (input m_vld, input m_dat, input m_last, output m_rdy);
endinterface

`default_nettype wire

// File: rtl/afifo_rd_ctrl.sv
// afifo_rd_ctrl: burst drain engine for the async FIFO read side with a 3-entry skid buffer.
// Optional idle-timeout partial drain is enabled by defining AFIFO_RD_TIMEOUT_EN.
`default_nettype none

module afifo_rd_ctrl #(
  parameter int DEEPWID = 3,
  parameter int BITWID  = 8,
  parameter int TOWID   = 8
) (
  input  wire logic               rd_clk_i,
  input  wire logic               rd_rst_i,
  output logic                    fifo_rd_o,
  input  wire logic [BITWID-1:0]  fifo_rd_dat_i,
  input  wire logic               fifo_rd_dat_vld_i,
  input  wire logic [DEEPWID:0]   fifo_rd_num_i,
  input  wire logic [DEEPWID:0]   cfg_burst_i,
  input  wire logic [TOWID-1:0]   cfg_timeout_i,
  input  wire logic               flush_i,
  output logic                    busy_o,
  afifo_rd_ctrl_if.master         m_if
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [DEEPWID:0] ONE = {{DEEPWID{1'b0}}, 1'b1};

  logic [1:0]             state_q, state_d;
  logic [DEEPWID:0]       len_q, len_d;
  logic [DEEPWID:0]       bcnt_q, bcnt_d;
  logic [DEEPWID:0]       wcnt_q, wcnt_d;
  logic                   inflight_q;
  logic [1:0]             cnt_q, cnt_d;
  logic [2:0][BITWID:0]   buf_q, buf_d;

  logic [DEEPWID:0] burst_eff;
  logic [DEEPWID:0] len_part;
  logic             readable, thr, trig, to_hit, room, pop, push;
  logic [BITWID:0]  entry;

  assign burst_eff = (cfg_burst_i == '0) ? ONE : cfg_burst_i;
  assign len_part  = (fifo_rd_num_i < burst_eff) ? fifo_rd_num_i : burst_eff;
  assign readable  = (fifo_rd_num_i != '0);
  assign thr       = (fifo_rd_num_i >= burst_eff);
  assign trig      = thr | (flush_i & readable) | (to_hit & readable);

  // Outstanding words (buffered + one in the FIFO read pipe) bound the issue rate.
  assign room      = (({1'b0, cnt_q} + {2'b00, inflight_q}) < 3'd3);
  assign fifo_rd_o = (state_q == S_BURST) & readable & room;
  assign busy_o    = (state_q != S_IDLE);

  assign m_if.m_vld  = (cnt_q != 2'd0);
  assign m_if.m_dat  = buf_q[0][BITWID:1];
  assign m_if.m_last = buf_q[0][0];

  assign pop   = m_if.m_vld & m_if.m_rdy;
  assign push  = fifo_rd_dat_vld_i;
  assign entry = {fifo_rd_dat_i, ((wcnt_q + ONE) == len_q)};

`ifdef AFIFO_RD_TIMEOUT_EN
  logic [TOWID-1:0] to_cnt_q, to_cnt_d;

  assign to_hit = (to_cnt_q == cfg_timeout_i) & (cfg_timeout_i != '0);

  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((state_q != S_IDLE) || trig || !readable) begin
      to_cnt_d = '0;
    end else if (!thr && (to_cnt_q != '1)) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge rd_clk_i or posedge rd_rst_i) begin
    if (rd_rst_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_cfg_timeout;
  assign unused_cfg_timeout = ^cfg_timeout_i;
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = push ? (wcnt_q + ONE) : wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_BURST;
          len_d   = thr ? burst_eff : len_part;
          bcnt_d  = '0;
          wcnt_d  = '0;
        end
      end
      S_BURST: begin
        if (fifo_rd_o) begin
          bcnt_d = bcnt_q + ONE;
          if ((bcnt_q + ONE) == len_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop & m_if.m_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Head-aligned shift buffer; vacated slots are zeroed so m_dat reads 0 when empty.
  always_comb begin
    logic [1:0] n;
    buf_d = buf_q;
    n     = cnt_q;
    if (pop) begin
      buf_d[0] = buf_q[1];
      buf_d[1] = buf_q[2];
      buf_d[2] = '0;
      n        = cnt_q - 2'd1;
    end
    if (push) begin
      case (n)
        2'd0:    buf_d[0] = entry;
        2'd1:    buf_d[1] = entry;
        default: buf_d[2] = entry;
      endcase
    end
    cnt_d = push ? (n + 2'd1) : n;
  end

  always_ff @(posedge rd_clk_i or posedge rd_rst_i) begin
    if (rd_rst_i) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      bcnt_q     <= '0;
      wcnt_q     <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      bcnt_q     <= bcnt_d;
      wcnt_q     <= wcnt_d;
      inflight_q <= fifo_rd_o;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge rd_clk_i) begin
    if (!rd_rst_i) begin
      assert (!(push && (cnt_q == 2'd3) && !pop))
        else $error("afifo_rd_ctrl: push into full output buffer");
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_afifo_rd_ctrl.sv
// tb_afifo_rd_ctrl: randomized and directed bench for afifo_rd_ctrl with a transaction-level model.
`default_nettype none

module tb_afifo_rd_ctrl;
  localparam int DW = 3;
  localparam int BW = 8;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_rd;
  logic [BW-1:0] fifo_rd_dat;
  logic          fifo_rd_dat_vld;
  logic [DW:0]   fifo_rd_num;
  logic [DW:0]   cfg_burst;
  logic [TW-1:0] cfg_timeout;
  logic          flush;
  logic          busy;

  always #5 clk = ~clk;

  afifo_rd_ctrl_if #(.BITWID(BW)) mif ();

  afifo_rd_ctrl #(.DEEPWID(DW), .BITWID(BW), .TOWID(TW)) dut (
    .rd_clk_i          (clk),
    .rd_rst_i          (rst),
    .fifo_rd_o         (fifo_rd),
    .fifo_rd_dat_i     (fifo_rd_dat),
    .fifo_rd_dat_vld_i (fifo_rd_dat_vld),
    .fifo_rd_num_i     (fifo_rd_num),
    .cfg_burst_i       (cfg_burst),
    .cfg_timeout_i     (cfg_timeout),
    .flush_i           (flush),
    .busy_o            (busy),
    .m_if              (mif.master)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         avail;
  } ent_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] fq[$];
  ent_t       eq[$];
  logic [8:0] acc_log[$];
  int         now = 0, ms = 0, len = 0, reads_left = 0, bidx = 0, outstanding = 0, to_cnt = 0;
  int         rd_cnt = 0, first_rd = -1, first_vld = -1;
  logic       pend_vld = 1'b0;
  logic [7:0] pend_dat = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, now, act, exp);
    end
  endtask

  task automatic clr_log();
    acc_log.delete();
    rd_cnt = 0;
    first_rd = -1;
    first_vld = -1;
  endtask

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) fq.push_back(base + 8'(i));
    fifo_rd_num = (DW+1)'(fq.size());
  endtask

  // One clock cycle: compare at negedge, advance the model, drive the FIFO side after the edge.
  task automatic step();
    int   beff, num, ms_before;
    bit   rd_exp, vld_exp, thr, hit, trig, lastacc;
    @(negedge clk);
    num     = fq.size();
    beff    = (cfg_burst == 0) ? 1 : int'(cfg_burst);
    rd_exp  = (ms == 1) && (num > 0) && (outstanding < 3);
    vld_exp = (eq.size() > 0) && (eq[0].avail <= now);
    chk("fifo_rd", 32'(fifo_rd), 32'(rd_exp));
    chk("busy", 32'(busy), 32'(ms != 0));
    chk("m_vld", 32'(mif.m_vld), 32'(vld_exp));
    if (vld_exp) begin
      chk("m_dat", 32'(mif.m_dat), 32'(eq[0].d));
      chk("m_last", 32'(mif.m_last), 32'(eq[0].l));
    end
    if (mif.m_vld && first_vld < 0) first_vld = now;
    lastacc = 1'b0;
    if (vld_exp && mif.m_rdy) begin
      lastacc = eq[0].l;
      acc_log.push_back({eq[0].d, eq[0].l});
      void'(eq.pop_front());
      outstanding--;
    end
    pend_vld = 1'b0;
    if (fifo_rd && num > 0) begin
      pend_dat = fq.pop_front();
      pend_vld = 1'b1;
      bidx++;
      reads_left--;
      outstanding++;
      eq.push_back('{pend_dat, (bidx == len), now + 2});
      rd_cnt++;
      if (first_rd < 0) first_rd = now;
    end
    ms_before = ms;
    trig = 1'b0;
    case (ms)
      0: begin
        thr = (num >= beff);
`ifdef AFIFO_RD_TIMEOUT_EN
        hit = (cfg_timeout != 0) && (to_cnt == int'(cfg_timeout));
`else
        hit = 1'b0;
`endif
        trig = thr || ((flush || hit) && num > 0);
        if (trig) begin
          ms = 1;
          len = thr ? beff : ((num < beff) ? num : beff);
          reads_left = len;
          bidx = 0;
        end
      end
      1: if (reads_left == 0) ms = 2;
      default: if (lastacc) ms = 0;
    endcase
    if (ms_before != 0 || trig || num == 0) to_cnt = 0;
    else if (num < beff && to_cnt < 255) to_cnt++;
    now++;
    @(posedge clk);
    #1;
    fifo_rd_dat_vld = pend_vld;
    fifo_rd_dat     = pend_vld ? pend_dat : 8'($urandom);
    fifo_rd_num     = (DW+1)'(fq.size());
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst fifo_rd", 32'(fifo_rd), 32'd0);
    chk("rst m_vld", 32'(mif.m_vld), 32'd0);
    chk("rst m_dat", 32'(mif.m_dat), 32'd0);
    chk("rst m_last", 32'(mif.m_last), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    fifo_rd_dat_vld = 1'b0;
    pend_vld = 1'b0;
    ms = 0; len = 0; reads_left = 0; bidx = 0; outstanding = 0; to_cnt = 0;
    eq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    fifo_rd_num = (DW+1)'(fq.size());
  endtask

  task automatic chk_log(input string name, input int n, input logic [7:0] base, input int last_mask);
    chk({name, " count"}, 32'(acc_log.size()), 32'(n));
    for (int i = 0; i < n && i < acc_log.size(); i++) begin
      logic [8:0] v;
      v = acc_log[i];
      chk({name, " dat"}, 32'(v[8:1]), 32'(base + 8'(i)));
      chk({name, " last"}, 32'(v[0]), 32'((last_mask >> i) & 1));
    end
  endtask

  initial begin
    int t0, guard;
    rst = 1'b1;
    fifo_rd_dat = '0; fifo_rd_dat_vld = 1'b0; fifo_rd_num = '0;
    cfg_burst = 4'd4; cfg_timeout = '0; flush = 1'b0; mif.m_rdy = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Full 4-word burst with the sink always ready.
    clr_log(); mif.m_rdy = 1'b1; t0 = now;
    load(4, 8'hA0);
    steps(10);
    chk("t1 rd count", 32'(rd_cnt), 32'd4);
    chk("t1 trig->rd", 32'(first_rd - t0), 32'd1);
    chk("t1 rd->vld", 32'(first_vld - first_rd), 32'd2);
    chk_log("t1", 4, 8'hA0, 4'b1000);
    chk("t1 busy end", 32'(busy), 32'd0);

    // Backpressure: three reads fill the buffer, head holds.
    clr_log(); mif.m_rdy = 1'b0;
    load(4, 8'hB0);
    steps(8);
    chk("t2 rd count", 32'(rd_cnt), 32'd3);
    chk("t2 head", 32'(mif.m_dat), 32'hB0);
    mif.m_rdy = 1'b1;
    steps(8);
    chk_log("t2", 4, 8'hB0, 4'b1000);

    // Partial burst via flush.
    clr_log();
    load(2, 8'hC0);
    steps(5);
    chk("t3 no read", 32'(rd_cnt), 32'd0);
    flush = 1'b1; step(); flush = 1'b0;
    steps(8);
    chk_log("t3", 2, 8'hC0, 2'b10);
    chk("t3 busy end", 32'(busy), 32'd0);

    // Single stranded word: timeout (if built in) or flush.
    clr_log(); cfg_timeout = 8'd10;
    load(1, 8'hD0);
    steps(9);
    chk("t4 no early read", 32'(rd_cnt), 32'd0);
`ifdef AFIFO_RD_TIMEOUT_EN
    steps(10);
`else
    steps(11);
    chk("t4 no timeout read", 32'(rd_cnt), 32'd0);
    flush = 1'b1; step(); flush = 1'b0;
    steps(6);
`endif
    chk_log("t4", 1, 8'hD0, 1);
    cfg_timeout = '0;

    // Reset mid-burst, then a fresh burst.
    clr_log();
    load(4, 8'hE0);
    guard = 0;
    while (acc_log.size() < 2 && guard < 20) begin step(); guard++; end
    chk("t5 reached 2 words", 32'(acc_log.size()), 32'd2);
    do_reset();
    clr_log();
    load(4, 8'hF0);
    steps(10);
    chk_log("t5", 4, 8'hF0, 4'b1000);

    // Burst length 0 behaves as 1.
    clr_log(); cfg_burst = 4'd0;
    load(3, 8'h60);
    steps(18);
    chk_log("t6", 3, 8'h60, 3'b111);

    // Randomized traffic, backpressure, config changes and flushes.
    for (int i = 0; i < 3000; i++) begin
      if (fq.size() < 8 && $urandom_range(0, 2) == 0) load(1, 8'($urandom));
      if ($urandom_range(0, 15) == 0) cfg_burst = 4'($urandom_range(0, 8));
      if ($urandom_range(0, 63) == 0) cfg_timeout = 8'($urandom_range(0, 15));
      mif.m_rdy = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 40) == 0);
      step();
      flush = 1'b0;
    end

    // Drain everything left.
    mif.m_rdy = 1'b1;
    guard = 0;
    while ((fq.size() != 0 || ms != 0) && guard < 200) begin
      flush = (ms == 0);
      step();
      flush = 1'b0;
      guard++;
    end
    chk("final drained", 32'(fq.size() + ms), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
